// File: rtl/link_pkg.sv
// Shared definitions for the byte link: master state encoding, default sizing
// and the byte width common to master and slave.
package link_pkg;

  localparam int BYTE_W      = 8;
  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 16;
  localparam int DEF_CNT_W   = 16;

  typedef enum logic [1:0] {
    S_IDLE         = 2'd0,
    S_REQ          = 2'd1,
    S_WAIT_ACK_LOW = 2'd2,
    S_ERR          = 2'd3
  } master_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Synchronous byte FIFO with a combinational head; pointers carry one extra
// wrap bit so full and empty are distinguished without a separate counter.
module byte_fifo
  import link_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [BYTE_W-1:0] wdata,
  output logic [BYTE_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic [BYTE_W-1:0] mem [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata   = mem[rptr[AW-1:0]];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/link_master_fsm.sv
// Transmit side of the byte link: buffers producer bytes and hands each one to
// the slave over a 4-phase req/ack handshake, with ack timeout and a sent count.
module link_master_fsm
  import link_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  output logic              in_ready,
  input  logic              ack,
  output logic              req,
  output logic [BYTE_W-1:0] data_out,
  output logic              busy,
  output logic [CNT_W-1:0]  sent_count,
  output logic              timeout_err,
  input  logic              err_clr
);

  localparam int TW = $clog2(TIMEOUT);

  master_state_t     state, state_next;
  logic [TW-1:0]     tcnt, tcnt_next;
  logic              req_next;
  logic [BYTE_W-1:0] data_next;
  logic [CNT_W-1:0]  sent_next;
  logic              err_next;
  logic              load;
  logic              pop;
  logic              full;
  logic              empty;
  logic [BYTE_W-1:0] head;

  byte_fifo #(.DEPTH(DEPTH)) fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (in_valid && !full),
    .pop   (pop),
    .wdata (in_data),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign in_ready = !full;
  assign busy     = (state != S_IDLE) || !empty;

  always_comb begin
    state_next = state;
    req_next   = req;
    data_next  = data_out;
    tcnt_next  = tcnt;
    sent_next  = sent_count;
    err_next   = timeout_err;
    load       = 1'b0;
    pop        = 1'b0;
    case (state)
      S_IDLE: begin
        req_next = 1'b0;
        if (!empty) load = 1'b1;
      end
      S_REQ: begin
        // ack is tested first so a late ack on the final cycle still counts.
        if (ack) begin
          req_next   = 1'b0;
          sent_next  = sent_count + CNT_W'(1);
          state_next = S_WAIT_ACK_LOW;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          req_next   = 1'b0;
          err_next   = 1'b1;
          state_next = S_ERR;
        end else begin
          tcnt_next = tcnt + TW'(1);
        end
      end
      S_WAIT_ACK_LOW: begin
        req_next = 1'b0;
        if (!ack) begin
          if (!empty) load = 1'b1;
          else        state_next = S_IDLE;
        end
      end
      S_ERR: begin
        req_next = 1'b0;
        if (err_clr) begin
          err_next   = 1'b0;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (load) begin
      pop        = 1'b1;
      data_next  = head;
      req_next   = 1'b1;
      tcnt_next  = '0;
      state_next = S_REQ;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      req         <= 1'b0;
      data_out    <= '0;
      tcnt        <= '0;
      sent_count  <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_next;
      req         <= req_next;
      data_out    <= data_next;
      tcnt        <= tcnt_next;
      sent_count  <= sent_next;
      timeout_err <= err_next;
    end
  end

endmodule

// File: doc/link_master_fsm.md
Name: link_master_fsm

Overview:
- Upstream transmit side of the byte link. Buffers bytes from a local producer and delivers each byte to the link slave over a 4-phase req/ack handshake.
- Sits between the producer (valid/ready interface) and the slave FSM. The slave latches data on the first cycle it sees req, then acks for 2 cycles, then waits for req to go low.
- Adds a per-byte ack timeout with a sticky error flag, and a count of delivered bytes.

Parameters:
- DEPTH, 4: FIFO entries. Power of 2, ≥2.
- TIMEOUT, 16: maximum cycles in S_REQ without ack before abort. Must be ≥2.
- CNT_W, 16: width of sent_count.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- in_valid  in  1  producer has a byte.
- in_data  in  8  producer byte.
- in_ready  out  1  FIFO can accept; equals !full.
- ack  in  1  from slave.
- req  out  1  to slave, registered.
- data_out  out  8  to slave, registered; stable whenever req=1.
- busy  out  1  state != S_IDLE or FIFO non-empty.
- sent_count  out  CNT_W  bytes acknowledged since reset; wraps modulo 2^CNT_W.
- timeout_err  out  1  sticky; set on timeout.
- err_clr  in  1  single-cycle pulse that clears timeout_err and leaves S_ERR.

Behaviour:
- Reset (rst=0, takes effect immediately, no clock needed):
  - state=S_IDLE, FIFO empty.
  - req=0, data_out=0, sent_count=0, timeout_err=0, timeout counter=0.
  - Reset mid-transfer drops req at once. The in-flight byte and FIFO contents are lost.
- FIFO write: a byte is written when in_valid && in_ready.
  - in_ready is computed from the registered occupancy, so a pop in the same cycle never enables a write while full.
  - Empty FIFO: a byte written in cycle N can be popped no earlier than cycle N+1.
- "Load" means: pop the FIFO head, data_out<=head, req<=1, timeout counter<=0, next state=S_REQ.
- S_IDLE:
  - req=0.
  - FIFO non-empty → load.
- S_REQ:
  - req=1, data_out held.
  - ack sampled 1 → req<=0, sent_count<=sent_count+1, go S_WAIT_ACK_LOW.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT-1 with ack still 0 → req<=0, timeout_err<=1, go S_ERR; the byte is discarded and not counted.
  - If ack=1 arrives on the same cycle the timeout would fire, ack wins.
- S_WAIT_ACK_LOW:
  - req=0.
  - ack=0 and FIFO non-empty → load directly (back-to-back).
  - ack=0 and FIFO empty → S_IDLE.
  - ack=1 → stay.
- S_ERR:
  - req=0; FIFO keeps accepting while not full.
  - err_clr=1 → timeout_err<=0, go S_IDLE.
  - err_clr in any other state is ignored.
- Throughput with the slave FSM: one byte per 4 cycles sustained.
- First-byte latency: req rises 1 cycle after the byte sits in a non-empty FIFO in S_IDLE.
- req never rises while ack=1.

Decomposition:
- Package link_pkg holds:
  - Master state encoding: S_IDLE, S_REQ, S_WAIT_ACK_LOW, S_ERR (2-bit).
  - Default DEPTH, TIMEOUT, CNT_W constants.
  - An 8-bit byte width constant shared with the slave.
- Sub-module byte_fifo: synchronous FIFO, DEPTH entries, 8-bit, same clk/rst.
  - Ports: push, pop, wdata, rdata (head, combinational), full, empty.
  - Read and write pointers are log2(DEPTH)+1 bits.

Test Plan:
1. Reset, then push 0xA5 with the slave FSM attached → req=1 with data_out=0xA5 one cycle after the pop. Slave last_byte=0xA5. sent_count=1. busy=0 once back in S_IDLE.
2. Push 0x01, 0x02, 0x03 back-to-back → three req rising edges spaced 4 cycles apart. Slave last_byte sequence 01, 02, 03. sent_count=3.
3. Stall the slave (ack tied 0), push 0x5A → req stays high for exactly TIMEOUT cycles, then req=0 and timeout_err=1. sent_count unchanged. Pulse err_clr → S_IDLE, timeout_err=0.
4. ack held 0, push 5 bytes with DEPTH=4 → the 1st byte pops into S_REQ and 4 more fill the FIFO, in_ready=0. After recovery, all remaining bytes deliver in order.
5. Assert rst=0 mid S_REQ → req=0 and data_out=0 in the same cycle, FIFO empty, sent_count=0. Normal operation resumes after rst=1.
6. Keep ack=1 for 3 extra cycles after req drops → the master stays in S_WAIT_ACK_LOW, and the next req rises only after ack=0 is sampled.
